// File: rtl/lfsr_scrambler_stream.sv
// Registered multi-bit Galois LFSR scrambler with valid/ready handshake and seed load.
// Each accepted word advances the LFSR by BITS steps, lsb of in_data_i first.
module lfsr_scrambler_stream #(
    parameter int unsigned       POLY_W   = 411,
    parameter int unsigned       BITS     = 12,
    parameter logic [POLY_W-1:0] TAP_MASK = (POLY_W'(1) << 31) | (POLY_W'(1) << 60) |
                                            (POLY_W'(1) << 190) | (POLY_W'(1) << 195) |
                                            (POLY_W'(1) << 245),
    parameter logic [POLY_W-1:0] SEED     = {POLY_W{1'b1}},
    parameter bit                MODE     = 1'b0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [POLY_W-1:0] load_value_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [BITS-1:0]   in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [BITS-1:0]   out_data_o,
    output logic [POLY_W-1:0] state_out_o,
    output logic [CNT_W-1:0]  word_count_o,
    output logic              zero_state_o
);

    logic [POLY_W-1:0] state_q, state_d;
    logic [POLY_W-1:0] state_out_q, state_out_d;
    logic [BITS-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic              zero_q, zero_d;

    logic [POLY_W-1:0] step_p;
    logic [BITS-1:0]   word_out;
    logic              msb;
    logic              accept;

    // Chain BITS Galois steps; msb is sampled before each shift.
    always_comb begin
        step_p   = state_q;
        word_out = '0;
        msb      = 1'b0;
        for (int i = 0; i < int'(BITS); i++) begin
            msb         = step_p[POLY_W-1];
            word_out[i] = MODE ? (msb ^ in_data_i[i]) : msb;
            step_p      = {step_p[POLY_W-2:0] ^ (TAP_MASK[POLY_W-1:1] & {(POLY_W-1){msb}}),
                           msb ^ in_data_i[i]};
        end
    end

    assign in_ready_o = !load_i && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        state_out_d = state_out_q;
        out_data_d  = out_data_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        if (load_i) begin
            state_d     = load_value_i;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            state_d     = step_p;
            state_out_d = step_p;
            out_data_d  = word_out;
            count_d     = count_q + CNT_W'(1);
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        zero_d = (state_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SEED;
            state_out_q <= '0;
            out_data_q  <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= (SEED == '0);
        end else begin
            state_q     <= state_d;
            state_out_q <= state_out_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign state_out_o  = state_out_q;
    assign word_count_o = count_q;
    assign zero_state_o = zero_q;

endmodule

// File: tb/tb_lfsr_scrambler_stream.sv
// Bench for lfsr_scrambler_stream: small-config vector table, default-config corner sequences,
// and a randomized additive-mode run against a polynomial reference model.
module tb_lfsr_scrambler_stream;

    typedef logic [410:0] st_t;
    localparam st_t TAP = (st_t'(1) << 31) | (st_t'(1) << 60) | (st_t'(1) << 190) |
                          (st_t'(1) << 195) | (st_t'(1) << 245);
    localparam st_t ONES = {411{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // small instance: POLY_W=4, BITS=1, x^4+x+1
    logic       s_load = 0, s_iv = 0, s_or = 1, s_ir, s_ov, s_z;
    logic [3:0] s_lv = '0, s_st;
    logic [0:0] s_din = '0, s_dout;
    logic [15:0] s_cnt;

    // default instance
    logic        d_load = 0, d_iv = 0, d_or = 1, d_ir, d_ov, d_z;
    st_t         d_lv = '0, d_st;
    logic [11:0] d_din = '0, d_dout;
    logic [15:0] d_cnt;

    // additive-mode instance, narrow counter so wrap is reached
    logic        r_load = 0, r_iv = 0, r_or = 1, r_ir, r_ov, r_z;
    st_t         r_lv = '0, r_st;
    logic [11:0] r_din = '0, r_dout;
    logic [7:0]  r_cnt;

    lfsr_scrambler_stream #(.POLY_W(4), .BITS(1), .TAP_MASK(4'b0010), .SEED(4'b1111),
                            .MODE(1'b0), .CNT_W(16)) u_small (
        .clk_i(clk), .rst_i(rst), .load_i(s_load), .load_value_i(s_lv), .in_valid_i(s_iv),
        .in_ready_o(s_ir), .in_data_i(s_din), .out_valid_o(s_ov), .out_ready_i(s_or),
        .out_data_o(s_dout), .state_out_o(s_st), .word_count_o(s_cnt), .zero_state_o(s_z));

    lfsr_scrambler_stream u_def (
        .clk_i(clk), .rst_i(rst), .load_i(d_load), .load_value_i(d_lv), .in_valid_i(d_iv),
        .in_ready_o(d_ir), .in_data_i(d_din), .out_valid_o(d_ov), .out_ready_i(d_or),
        .out_data_o(d_dout), .state_out_o(d_st), .word_count_o(d_cnt), .zero_state_o(d_z));

    lfsr_scrambler_stream #(.MODE(1'b1), .CNT_W(8)) u_add (
        .clk_i(clk), .rst_i(rst), .load_i(r_load), .load_value_i(r_lv), .in_valid_i(r_iv),
        .in_ready_o(r_ir), .in_data_i(r_din), .out_valid_o(r_ov), .out_ready_i(r_or),
        .out_data_o(r_dout), .state_out_o(r_st), .word_count_o(r_cnt), .zero_state_o(r_z));

    task automatic chk(input string name, input st_t act, input st_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Multiply by x modulo P(x) = x^411 + taps + 1, then add the data bit.
    function automatic void model_word(input st_t p_in, input logic [11:0] d, input bit mode,
                                       output st_t p_out, output logic [11:0] o);
        st_t p = p_in;
        for (int i = 0; i < 12; i++) begin
            bit m = p[410];
            o[i] = mode ? (m ^ d[i]) : m;
            p = (p << 1) ^ (m ? (TAP | st_t'(1)) : '0) ^ st_t'(d[i]);
        end
        p_out = p;
    endfunction

    typedef struct {
        logic [3:0] seed;
        logic       din;
        logic       exp_out;
        logic [3:0] exp_st;
    } vec_t;
    vec_t vecs[6];

    initial begin
        st_t         ms, mst, lv;
        logic [11:0] mo, mout;
        bit          mv;
        int          acc;

        vecs[0] = '{4'b1000, 1'b0, 1'b1, 4'b0011};
        vecs[1] = '{4'b0000, 1'b1, 1'b0, 4'b0001};
        vecs[2] = '{4'b0101, 1'b0, 1'b0, 4'b1010};
        vecs[3] = '{4'b0101, 1'b1, 1'b0, 4'b1011};
        vecs[4] = '{4'b1111, 1'b1, 1'b1, 4'b1100};
        vecs[5] = '{4'b1001, 1'b1, 1'b1, 4'b0000};

        // reset wins over simultaneous load and in_valid
        d_load = 1; d_iv = 1; d_lv = st_t'(5); d_din = 12'hFFF;
        repeat (2) @(negedge clk);
        chk("rst out_valid", st_t'(d_ov), '0);
        chk("rst count", st_t'(d_cnt), '0);
        chk("rst state_out", d_st, '0);
        chk("rst out_data", st_t'(d_dout), '0);
        chk("rst zero_state", st_t'(d_z), '0);
        chk("rst small zero", st_t'(s_z), '0);
        rst = 0; d_load = 0; d_iv = 0;

        // state after reset is SEED
        d_iv = 1; d_din = 12'hA5C;
        @(negedge clk);
        model_word(ONES, 12'hA5C, 1'b0, ms, mo);
        chk("seed word valid", st_t'(d_ov), st_t'(1));
        chk("seed word state", d_st, ms);
        chk("seed word data", st_t'(d_dout), st_t'(mo));
        chk("seed word count", st_t'(d_cnt), st_t'(1));

        // load with in_valid: no word consumed, pending output discarded
        lv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        d_load = 1; d_lv = lv; d_din = 12'h7E1;
        #1 chk("load in_ready", st_t'(d_ir), '0);
        @(negedge clk);
        chk("load out_valid", st_t'(d_ov), '0);
        chk("load count", st_t'(d_cnt), '0);
        d_load = 0; d_din = 12'h003;
        @(negedge clk);
        model_word(lv, 12'h003, 1'b0, ms, mo);
        chk("post-load state", d_st, ms);
        chk("post-load data", st_t'(d_dout), st_t'(mo));
        chk("post-load count", st_t'(d_cnt), st_t'(1));
        d_iv = 0;

        // zero-state lockup, then escape via input bit
        d_load = 1; d_lv = '0;
        @(negedge clk);
        d_load = 0;
        chk("zero after load", st_t'(d_z), st_t'(1));
        d_iv = 1; d_din = 12'h000;
        @(negedge clk);
        chk("lockup state", d_st, '0);
        chk("lockup data", st_t'(d_dout), '0);
        chk("lockup zero", st_t'(d_z), st_t'(1));
        d_din = 12'h001;
        @(negedge clk);
        chk("escape state", d_st, st_t'(12'h800));
        chk("escape data", st_t'(d_dout), '0);
        chk("escape count", st_t'(d_cnt), st_t'(2));
        chk("escape zero", st_t'(d_z), '0);
        d_iv = 0;

        // small-config vector table
        foreach (vecs[k]) begin
            s_load = 1; s_lv = vecs[k].seed; s_iv = 0;
            @(negedge clk);
            s_load = 0;
            chk($sformatf("vec%0d zero before", k), st_t'(s_z), st_t'(vecs[k].seed == 4'b0));
            s_iv = 1; s_din = vecs[k].din;
            @(negedge clk);
            s_iv = 0;
            chk($sformatf("vec%0d valid", k), st_t'(s_ov), st_t'(1));
            chk($sformatf("vec%0d data", k), st_t'(s_dout), st_t'(vecs[k].exp_out));
            chk($sformatf("vec%0d state", k), st_t'(s_st), st_t'(vecs[k].exp_st));
            chk($sformatf("vec%0d count", k), st_t'(s_cnt), st_t'(1));
            chk($sformatf("vec%0d zero", k), st_t'(s_z), st_t'(vecs[k].exp_st == 4'b0));
        end

        // randomized additive mode with a 5-cycle backpressure burst at the start
        ms = ONES; mv = 0; acc = 0; mst = '0; mout = '0;
        for (int cyc = 0; cyc < 8000 && acc < 1000; cyc++) begin
            bit acpt;
            @(negedge clk);
            chk("rnd out_valid", st_t'(r_ov), st_t'(mv));
            chk("rnd zero", st_t'(r_z), st_t'(ms == '0));
            if (mv) begin
                chk("rnd data", st_t'(r_dout), st_t'(mout));
                chk("rnd state", r_st, mst);
                chk("rnd count", st_t'(r_cnt), st_t'(acc % 256));
            end
            if (cyc < 7) begin
                r_iv = 1; r_or = !(cyc >= 1 && cyc < 6);
            end else begin
                r_iv = ($urandom_range(0, 3) != 0);
                r_or = ($urandom_range(0, 3) != 0);
            end
            r_din = 12'($urandom);
            acpt = r_iv && (!mv || r_or);
            #1 chk("rnd in_ready", st_t'(r_ir), st_t'(!mv || r_or));
            if (acpt) begin
                model_word(ms, r_din, 1'b1, ms, mout);
                mst = ms; mv = 1; acc++;
            end else if (r_or) begin
                mv = 0;
            end
        end
        @(negedge clk);
        chk("rnd final state", r_st, mst);
        chk("rnd final count", st_t'(r_cnt), st_t'(acc % 256));
        chk("rnd words done", st_t'(acc >= 1000), st_t'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
